gte_microcode_sequencer: RTL and testbench
==========================================

GTE_MICROCODE_SEQUENCER -- requirements
Module: gte_microcode_sequencer

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 2, datapath pipeline flush cycles after last microcode step (legal 0..7).
REQ-002 Port: i_clk  in  1  sole clock, all logic rising-edge.
REQ-003 Port: i_nRst  in  1  reset, synchronous, active-low.
REQ-004 Port: i_cmdValid  in  1  command issue strobe.
REQ-005 Port: i_cmdOpcode  in  6  GTE command opcode.
REQ-006 Port: i_cmdIsNop  in  1  command decodes as NOP.
REQ-007 Port: i_cmdBuggyMVMVA  in  1  command is the invalid-matrix MVMVA variant.
REQ-008 Port: o_cmdReady  out  1  sequencer accepts a command this cycle.
REQ-009 Port: o_decOpcode / o_decIsNop / o_decBuggyMVMVA  out  6/1/1  latched command fields, driving the start-address decoder.
REQ-010 Port: i_decStartAddr  in  9  combinational start address returned by the decoder.
REQ-011 Port: o_romAddr  out  9  microcode ROM address.
REQ-012 Port: o_romRead  out  1  ROM read enable; the ROM word is valid the next cycle and is held while o_romRead=0.
REQ-013 Port: i_romLast  in  1  last-step flag of the current ROM word.
REQ-014 Port: i_stall  in  1  datapath stall request.
REQ-015 Port: o_stepValid  out  1  current ROM word executes this cycle.
REQ-016 Port: o_busy  out  1  command in progress.
REQ-017 Port: o_done  out  1  one-cycle completion pulse.

Function
REQ-018 States: IDLE, LOOKUP, RUN, DRAIN, DONE.
REQ-019 o_cmdReady=1 only in IDLE; accept = i_cmdValid & o_cmdReady; i_cmdValid outside IDLE is ignored and not queued.
REQ-020 On accept (cycle A): latch opcode, IsNop and BuggyMVMVA into o_dec* registers; next state LOOKUP.
REQ-021 LOOKUP (cycle A+1): o_romAddr=i_decStartAddr, o_romRead=1, pc<=i_decStartAddr+1; next state RUN.
REQ-022 RUN, i_stall=0: o_stepValid=1; if i_romLast=0: o_romRead=1, o_romAddr=pc, pc<=pc+1.
REQ-023 RUN, i_stall=1: o_stepValid=0, o_romRead=0, pc held; the same ROM word re-executes once the stall ends.
REQ-024 RUN, o_stepValid=1 and i_romLast=1: o_romRead=0 (no prefetch past last); next state DRAIN if DRAIN_CYCLES>0, else DONE.
REQ-025 pc is 9-bit and wraps 511->0 without error.
REQ-026 DRAIN: counts DRAIN_CYCLES cycles; the count freezes while i_stall=1; then goes to DONE.
REQ-027 DONE: o_done=1 for exactly one cycle; next state IDLE; a new command is accepted no earlier than the following cycle.
REQ-028 o_busy=1 in LOOKUP, RUN, DRAIN and DONE; 0 in IDLE.
REQ-029 Unstalled latency: o_done asserted at cycle A+2+N+DRAIN_CYCLES, where N is the number of microcode steps.
REQ-030 o_romAddr holds its last value whenever o_romRead=0.

Reset
REQ-031 When i_nRst=0 at a clock edge: state=IDLE, pc=0, drain count=0, o_dec*=0, o_romAddr=0, o_romRead=0, o_stepValid=0, o_busy=0, o_done=0, o_cmdReady=0 during reset and 1 from the first cycle after release.
REQ-032 Reset mid-command abandons the command with no o_done pulse.

Configuration
REQ-033 Macro GTE_SEQ_NOP_SKIP_EN defined: an accepted command with i_cmdIsNop=1 goes from IDLE directly to DONE (o_done at A+1), with no ROM access.
REQ-034 Macro GTE_SEQ_NOP_SKIP_EN undefined: NOP commands are sequenced like any other command through the ROM.

Structure
REQ-035 Shared package gte_seq_pkg holds the state enum and the widths UC_ADDR_W=9 and OPCODE_W=6.
REQ-036 One sub-module, gte_uc_pc, implements the pc register, its load, increment and wrap.

Verification
REQ-037 Accept opcode 0x06, start address 0x040, 3-step microcode, no stall, DRAIN_CYCLES=2 -> o_romAddr sequence 0x040, 0x041, 0x042; o_done at A+7.
REQ-038 i_stall=1 for 2 cycles during step 2 -> o_stepValid low for 2 cycles, no address skipped, o_done delayed by 2 cycles.
REQ-039 Start address 0x1FF, 2 steps -> second read at address 0x000.
REQ-040 i_cmdValid pulsed during RUN -> ignored; exactly one o_done; next command is accepted only after IDLE is reached.
REQ-041 i_nRst=0 during RUN -> all outputs return to reset values; no o_done pulse.
REQ-042 NOP command with GTE_SEQ_NOP_SKIP_EN defined -> o_done at A+1 and o_romRead never asserted; without the macro -> ROM sequenced normally.

Source files
------------

// File: rtl/gte_seq_pkg.sv
// ----------------------------------------------------------------------------
// gte_seq_pkg
// Shared definitions for the GTE microcode sequencer: address/opcode widths,
// the sequencer state enum and the pc increment helper.
// ----------------------------------------------------------------------------
package gte_seq_pkg;

    localparam int unsigned UC_ADDR_W = 9;
    localparam int unsigned OPCODE_W  = 6;

    typedef logic [UC_ADDR_W-1:0] uc_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Microcode addresses wrap 511 -> 0 by plain 9-bit overflow.
    function automatic uc_addr_t uc_addr_next(input uc_addr_t a);
        return a + uc_addr_t'(1);
    endfunction

endpackage

// File: rtl/gte_uc_pc.sv
// ----------------------------------------------------------------------------
// gte_uc_pc
// Microcode program counter. A load captures the address following the
// start address (the start word itself is fetched directly from the decoder),
// an increment advances by one; both wrap within the 9-bit address space.
//
// Ports:
//   i_clk       clock, rising edge
//   i_nRst      synchronous active-low reset (pc -> 0)
//   i_load      load pc with i_loadAddr + 1
//   i_loadAddr  start address from the decoder
//   i_inc       advance pc by one (ignored when i_load is set)
//   o_pc        current pc
// ----------------------------------------------------------------------------
module gte_uc_pc
    import gte_seq_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_nRst,
    input  logic                 i_load,
    input  logic [UC_ADDR_W-1:0] i_loadAddr,
    input  logic                 i_inc,
    output logic [UC_ADDR_W-1:0] o_pc
);

    logic [UC_ADDR_W-1:0] pc_q;
    logic [UC_ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_load) begin
            pc_d = uc_addr_next(i_loadAddr);
        end else if (i_inc) begin
            pc_d = uc_addr_next(pc_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/gte_microcode_sequencer.sv
// ----------------------------------------------------------------------------
// gte_microcode_sequencer
// Sequences one GTE command through the microcode ROM:
// IDLE -> LOOKUP -> RUN -> DRAIN -> DONE -> IDLE.
// The accepted command fields are latched onto o_dec*, the external decoder
// returns the start address, and the ROM is walked until a word flagged
// last executes, followed by DRAIN_CYCLES pipeline flush cycles.
//
// Parameters:
//   DRAIN_CYCLES     flush cycles after the last step (0..7)
// Optional build macro:
//   GTE_SEQ_NOP_SKIP_EN  NOP commands skip straight from IDLE to DONE
//
// Ports:
//   i_clk, i_nRst            clock, synchronous active-low reset
//   i_cmdValid               command issue strobe
//   i_cmdOpcode/IsNop/BuggyMVMVA  command fields
//   o_cmdReady               command accepted this cycle if i_cmdValid
//   o_decOpcode/IsNop/BuggyMVMVA  latched command fields to the decoder
//   i_decStartAddr           decoder start address (combinational)
//   o_romAddr, o_romRead     ROM fetch; word valid the following cycle
//   i_romLast                last-step flag of the current ROM word
//   i_stall                  datapath stall
//   o_stepValid              current ROM word executes this cycle
//   o_busy, o_done           command in progress / completion pulse
// ----------------------------------------------------------------------------
module gte_microcode_sequencer
    import gte_seq_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
)
(
    input  logic                 i_clk,
    input  logic                 i_nRst,
    input  logic                 i_cmdValid,
    input  logic [OPCODE_W-1:0]  i_cmdOpcode,
    input  logic                 i_cmdIsNop,
    input  logic                 i_cmdBuggyMVMVA,
    output logic                 o_cmdReady,
    output logic [OPCODE_W-1:0]  o_decOpcode,
    output logic                 o_decIsNop,
    output logic                 o_decBuggyMVMVA,
    input  logic [UC_ADDR_W-1:0] i_decStartAddr,
    output logic [UC_ADDR_W-1:0] o_romAddr,
    output logic                 o_romRead,
    input  logic                 i_romLast,
    input  logic                 i_stall,
    output logic                 o_stepValid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [2:0] DRAIN_LAST =
        (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

    seq_state_e           state_q, state_d;
    logic [2:0]           drain_q, drain_d;
    logic                 ready_q;
    logic [OPCODE_W-1:0]  decOpcode_q;
    logic                 decIsNop_q;
    logic                 decBuggy_q;
    logic [UC_ADDR_W-1:0] romAddr_q;

    logic                 accept;
    logic                 step_valid;
    logic                 rom_read;
    logic [UC_ADDR_W-1:0] rom_addr;
    logic                 pc_load;
    logic                 pc_inc;
    logic [UC_ADDR_W-1:0] pc;

    gte_uc_pc u_pc (
        .i_clk      (i_clk),
        .i_nRst     (i_nRst),
        .i_load     (pc_load),
        .i_loadAddr (i_decStartAddr),
        .i_inc      (pc_inc),
        .o_pc       (pc)
    );

    assign accept = i_cmdValid & ready_q;

    // ROM fetch and step strobes are decoded from the current state within
    // the cycle: the start address only exists once o_dec* is latched, and a
    // stall must suppress the step in the same cycle it is raised.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        step_valid = 1'b0;
        rom_read   = 1'b0;
        rom_addr   = romAddr_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef GTE_SEQ_NOP_SKIP_EN
                    state_d = i_cmdIsNop ? ST_DONE : ST_LOOKUP;
`else
                    state_d = ST_LOOKUP;
`endif
                end
            end
            ST_LOOKUP: begin
                rom_read = 1'b1;
                rom_addr = i_decStartAddr;
                pc_load  = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (!i_stall) begin
                    step_valid = 1'b1;
                    if (!i_romLast) begin
                        rom_read = 1'b1;
                        rom_addr = pc;
                        pc_inc   = 1'b1;
                    end else begin
                        drain_d = '0;
                        state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!i_stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            ready_q     <= 1'b0;
            decOpcode_q <= '0;
            decIsNop_q  <= 1'b0;
            decBuggy_q  <= 1'b0;
            romAddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            // Ready tracks the next state so it is registered, and stays low
            // for the first cycle after reset release.
            ready_q   <= (state_d == ST_IDLE);
            romAddr_q <= rom_addr;
            if (accept) begin
                decOpcode_q <= i_cmdOpcode;
                decIsNop_q  <= i_cmdIsNop;
                decBuggy_q  <= i_cmdBuggyMVMVA;
            end
        end
    end

    assign o_cmdReady      = ready_q;
    assign o_decOpcode     = decOpcode_q;
    assign o_decIsNop      = decIsNop_q;
    assign o_decBuggyMVMVA = decBuggy_q;
    assign o_romAddr       = rom_addr;
    assign o_romRead       = rom_read;
    assign o_stepValid     = step_valid;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_gte_microcode_sequencer.sv
module tb_gte_microcode_sequencer;

    localparam int DRAIN  = 2;
    localparam int BUDGET = 40;
`ifdef GTE_SEQ_NOP_SKIP_EN
    localparam bit NOP_SKIP = 1'b1;
`else
    localparam bit NOP_SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       nRst = 1'b0;
    logic       cmdValid = 1'b0;
    logic [5:0] cmdOpcode = '0;
    logic       cmdIsNop = 1'b0;
    logic       cmdBuggy = 1'b0;
    logic       stall = 1'b0;
    logic       cmdReady, decIsNop, decBuggy, romRead, romLast, stepValid, busy, done;
    logic [5:0] decOpcode;
    logic [8:0] decStartAddr, romAddr;

    gte_microcode_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
        .i_clk           (clk),
        .i_nRst          (nRst),
        .i_cmdValid      (cmdValid),
        .i_cmdOpcode     (cmdOpcode),
        .i_cmdIsNop      (cmdIsNop),
        .i_cmdBuggyMVMVA (cmdBuggy),
        .o_cmdReady      (cmdReady),
        .o_decOpcode     (decOpcode),
        .o_decIsNop      (decIsNop),
        .o_decBuggyMVMVA (decBuggy),
        .i_decStartAddr  (decStartAddr),
        .o_romAddr       (romAddr),
        .o_romRead       (romRead),
        .i_romLast       (romLast),
        .i_stall         (stall),
        .o_stepValid     (stepValid),
        .o_busy          (busy),
        .o_done          (done)
    );

    // Decoder and ROM models: programs are defined by a start address per
    // opcode (offset by 0x80 for the buggy MVMVA variant) and a step count.
    logic [8:0] start_tbl [64];
    int         len_tbl   [64];
    logic [8:0] word_addr = '0;
    logic [8:0] cur_start = '0;
    int         cur_len   = 1;

    assign decStartAddr = start_tbl[decOpcode] + (decBuggy ? 9'h080 : 9'h000);
    assign romLast      = ((word_addr - cur_start) == 9'(cur_len - 1));

    always @(posedge clk) if (romRead) word_addr <= romAddr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exec_q [$];
    logic [8:0] read_q [$];
    logic [8:0] last_rd = '0;
    int done_off, n_done;
    bit busy_bad, ready_bad, hold_bad, dec_bad;

    typedef struct {
        logic [5:0] op;
        logic       nop;
        logic       bug;
        int         stall_at;
        int         stall_len;
        int         pulse_at;
        logic [8:0] exp_start;
        int         exp_len;
        int         exp_done;
        logic [8:0] exp_last;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [5:0] op, input logic nop, input logic bug,
                           input int stall_at, input int stall_len, input int pulse_at);
        bit accepted;
        accepted = 1'b0;
        exec_q.delete();
        read_q.delete();
        done_off = -1; n_done = 0;
        busy_bad = 0; ready_bad = 0; hold_bad = 0; dec_bad = 0;
        cur_start = start_tbl[op] + (bug ? 9'h080 : 9'h000);
        cur_len   = len_tbl[op];
        for (int w = 0; w < 10 && !accepted; w++) begin
            @(posedge clk); #1;
            cmdValid = 1'b1; cmdOpcode = op; cmdIsNop = nop; cmdBuggy = bug; stall = 1'b0;
            @(negedge clk);
            accepted = cmdReady;
        end
        chk("accept", 32'(accepted), 32'd1);
        if (!accepted) begin
            cmdValid = 1'b0;
            return;
        end
        for (int off = 1; off <= BUDGET; off++) begin
            @(posedge clk); #1;
            stall    = (off >= stall_at) && (off < stall_at + stall_len);
            cmdValid = (off == pulse_at);
            cmdOpcode = ~op; cmdIsNop = ~nop; cmdBuggy = ~bug;
            @(negedge clk);
            if (decOpcode !== op || decIsNop !== nop || decBuggy !== bug) dec_bad = 1;
            if (stepValid) exec_q.push_back(word_addr);
            if (romRead) begin
                read_q.push_back(romAddr);
                last_rd = romAddr;
            end else if (romAddr !== last_rd) begin
                hold_bad = 1;
            end
            if (done) begin
                n_done++;
                if (done_off < 0) done_off = off;
            end
            if (done_off >= 0 && off == done_off + 1) begin
                if (busy !== 1'b0 || cmdReady !== 1'b1) ready_bad = 1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
            if (cmdReady !== 1'b0) ready_bad = 1;
        end
        cmdValid = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic eval_cmd(input string tag, input logic [8:0] exp_start, input int exp_len,
                            input int exp_done, input logic [8:0] exp_last);
        bit seq_bad;
        logic [8:0] lastr;
        seq_bad = 0;
        lastr   = 9'h155;
        for (int k = 0; k < exec_q.size(); k++)
            if (exec_q[k] !== exp_start + 9'(k)) seq_bad = 1;
        for (int k = 0; k < read_q.size(); k++)
            if (read_q[k] !== exp_start + 9'(k)) seq_bad = 1;
        if (read_q.size() > 0) lastr = read_q[read_q.size() - 1];
        chk({tag, " done_cycle"}, 32'(done_off), 32'(exp_done));
        chk({tag, " done_pulses"}, 32'(n_done), 32'd1);
        chk({tag, " steps"}, 32'(exec_q.size()), 32'(exp_len));
        chk({tag, " rom_reads"}, 32'(read_q.size()), 32'(exp_len));
        chk({tag, " addr_seq_err"}, 32'(seq_bad), 32'd0);
        chk({tag, " addr_hold_err"}, 32'(hold_bad), 32'd0);
        chk({tag, " busy_err"}, 32'(busy_bad), 32'd0);
        chk({tag, " ready_err"}, 32'(ready_bad), 32'd0);
        chk({tag, " dec_err"}, 32'(dec_bad), 32'd0);
        if (exp_len > 0) chk({tag, " last_addr"}, 32'(lastr), 32'(exp_last));
    endtask

    // Reference timing: after LOOKUP, N steps then DRAIN flush cycles each
    // need one unstalled cycle; DONE follows the last of them.
    function automatic int model_done(input int len, input bit skip,
                                      input int stall_at, input int stall_len);
        int t, rem;
        if (skip) return 1;
        t   = 2;
        rem = len + DRAIN;
        while (rem > 0) begin
            if (!(t >= stall_at && t < stall_at + stall_len)) rem--;
            t++;
        end
        return t;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " romRead"}, 32'(romRead), 32'd0);
        chk({tag, " romAddr"}, 32'(romAddr), 32'd0);
        chk({tag, " stepValid"}, 32'(stepValid), 32'd0);
        chk({tag, " cmdReady"}, 32'(cmdReady), 32'd0);
        chk({tag, " dec"}, 32'({decOpcode, decIsNop, decBuggy}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic       bug, nop;
        int         s_at, s_len, p_at, exp_d, exp_n, n_rst_done;
        logic [8:0] exp_s;

        for (int i = 0; i < 64; i++) begin
            start_tbl[i] = 9'(i * 37);
            len_tbl[i]   = 1 + (i % 6);
        end
        start_tbl[6'h06] = 9'h040; len_tbl[6'h06] = 3;
        start_tbl[6'h3F] = 9'h1FF; len_tbl[6'h3F] = 2;
        start_tbl[6'h1A] = 9'h100; len_tbl[6'h1A] = 4;
        start_tbl[6'h01] = 9'h010; len_tbl[6'h01] = 1;
        start_tbl[6'h00] = 9'h020; len_tbl[6'h00] = 2;

        //              op     nop   bug   s_at s_len pulse start   len done last
        vecs[0] = '{6'h06, 1'b0, 1'b0, 0, 0, 3, 9'h040, 3, 7,  9'h042};
        vecs[1] = '{6'h06, 1'b0, 1'b0, 3, 2, 0, 9'h040, 3, 9,  9'h042};
        vecs[2] = '{6'h3F, 1'b0, 1'b0, 0, 0, 0, 9'h1FF, 2, 6,  9'h000};
        vecs[3] = '{6'h1A, 1'b0, 1'b1, 0, 0, 2, 9'h180, 4, 8,  9'h183};
        vecs[4] = '{6'h06, 1'b0, 1'b0, 5, 3, 0, 9'h040, 3, 10, 9'h042};
        vecs[5] = '{6'h01, 1'b0, 1'b0, 0, 0, 0, 9'h010, 1, 5,  9'h010};
        vecs[6] = '{6'h01, 1'b0, 1'b0, 2, 1, 4, 9'h010, 1, 6,  9'h010};
        if (NOP_SKIP) vecs[7] = '{6'h00, 1'b1, 1'b0, 0, 0, 0, 9'h020, 0, 1, 9'h000};
        else          vecs[7] = '{6'h00, 1'b1, 1'b0, 0, 0, 0, 9'h020, 2, 6, 9'h021};

        // Power-on reset
        nRst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("por ready_after_release", 32'(cmdReady), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].nop, vecs[i].bug,
                    vecs[i].stall_at, vecs[i].stall_len, vecs[i].pulse_at);
            eval_cmd($sformatf("vec%0d", i), vecs[i].exp_start, vecs[i].exp_len,
                     vecs[i].exp_done, vecs[i].exp_last);
        end

        // Reset while RUN is executing step 2: command abandoned, no done.
        @(posedge clk); #1;
        cmdValid = 1'b1; cmdOpcode = 6'h06; cmdIsNop = 1'b0; cmdBuggy = 1'b0;
        cur_start = 9'h040; cur_len = 3;
        @(negedge clk);
        chk("rst_mid accept", 32'(cmdReady), 32'd1);
        for (int off = 1; off <= 3; off++) begin
            @(posedge clk); #1;
            cmdValid = 1'b0;
            @(negedge clk);
        end
        chk("rst_mid in_run", 32'(stepValid), 32'd1);
        @(posedge clk); #1;
        nRst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        last_rd = '0;
        @(posedge clk); #1;
        nRst = 1'b1;
        n_rst_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) n_rst_done++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_mid no_done", 32'(n_rst_done), 32'd0);
        chk("rst_mid ready", 32'(cmdReady), 32'd1);
        chk("rst_mid busy", 32'(busy), 32'd0);

        // Randomized commands against the reference model
        for (int r = 0; r < 30; r++) begin
            op    = 6'($urandom_range(0, 63));
            bug   = 1'($urandom_range(0, 1));
            nop   = (op == 6'h00);
            s_at  = $urandom_range(2, 12);
            s_len = $urandom_range(0, 3);
            p_at  = (NOP_SKIP && nop) ? 0 : $urandom_range(1, 4);
            exp_s = start_tbl[op] + (bug ? 9'h080 : 9'h000);
            exp_n = (NOP_SKIP && nop) ? 0 : len_tbl[op];
            exp_d = model_done(len_tbl[op], NOP_SKIP && nop, s_at, s_len);
            run_cmd(op, nop, bug, s_at, s_len, p_at);
            eval_cmd($sformatf("rnd%0d op%0h", r, op), exp_s, exp_n, exp_d,
                     exp_s + 9'(exp_n - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
